// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: a Q8.8 kernel applied to an unsigned pixel window, in four registered
// stages (multiply, row sums, total, round/ReLU/saturate), one window per cycle.
module conv3x3_mac #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned FRAC_BITS = 8,
  parameter bit          RELU      = 1'b0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        pix_1_1,
  input  logic [PIX_W-1:0]        pix_1_2,
  input  logic [PIX_W-1:0]        pix_1_3,
  input  logic [PIX_W-1:0]        pix_2_1,
  input  logic [PIX_W-1:0]        pix_2_2,
  input  logic [PIX_W-1:0]        pix_2_3,
  input  logic [PIX_W-1:0]        pix_3_1,
  input  logic [PIX_W-1:0]        pix_3_2,
  input  logic [PIX_W-1:0]        pix_3_3,
  input  logic                    pix_valid,
  input  logic signed [15:0]      weights_1_1,
  input  logic signed [15:0]      weights_1_2,
  input  logic signed [15:0]      weights_1_3,
  input  logic signed [15:0]      weights_2_1,
  input  logic signed [15:0]      weights_2_2,
  input  logic signed [15:0]      weights_2_3,
  input  logic signed [15:0]      weights_3_1,
  input  logic signed [15:0]      weights_3_2,
  input  logic signed [15:0]      weights_3_3,
  input  logic signed [15:0]      bias,
  input  logic                    weights_ready,
  output logic signed [15:0]      conv_out,
  output logic                    conv_valid,
  output logic                    sat_flag,
  output logic [15:0]             sat_cnt
);

  localparam int unsigned ProdW = PIX_W + 17;
  localparam int unsigned SumW  = ProdW + 2;
  localparam int unsigned AccW  = ProdW + 4;
  localparam int unsigned RndW  = AccW + 1;

  localparam logic signed [RndW-1:0] Half   = RndW'(1) << (FRAC_BITS - 1);
  localparam logic signed [RndW-1:0] OutMax = RndW'(32767);
  localparam logic signed [RndW-1:0] OutMin = RndW'(-32768);

  logic [PIX_W-1:0]   pix [9];
  logic signed [15:0] wgt [9];

  assign pix = '{pix_1_1, pix_1_2, pix_1_3, pix_2_1, pix_2_2, pix_2_3, pix_3_1, pix_3_2, pix_3_3};
  assign wgt = '{weights_1_1, weights_1_2, weights_1_3, weights_2_1, weights_2_2, weights_2_3,
                 weights_3_1, weights_3_2, weights_3_3};

  logic signed [ProdW-1:0] prod_q [9];
  logic signed [SumW-1:0]  row_q  [3];
  logic signed [AccW-1:0]  acc_q;
  logic                    v1_q, v2_q, v3_q, wr_q;
  logic                    accept, adv2, adv3, adv4;

  // A low weights_ready at any edge kills every in-flight window.
  assign accept = pix_valid & weights_ready;
  assign adv2   = v1_q & weights_ready;
  assign adv3   = v2_q & weights_ready;
  assign adv4   = v3_q & weights_ready;

  always_ff @(posedge pclk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      conv_valid <= 1'b0;
    end else begin
      v1_q       <= accept;
      v2_q       <= adv2;
      v3_q       <= adv3;
      conv_valid <= adv4;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= ProdW'($signed({1'b0, pix[i]})) * ProdW'(wgt[i]);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) row_q[r] <= '0;
    end else if (adv2) begin
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= SumW'(prod_q[3*r]) + SumW'(prod_q[3*r+1]) + SumW'(prod_q[3*r+2]);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (adv3) begin
      acc_q <= AccW'(row_q[0]) + AccW'(row_q[1]) + AccW'(row_q[2]) + AccW'(bias);
    end
  end

  logic signed [RndW-1:0] rnd;
  logic signed [15:0]     out_d;
  logic                   sat_d;

  // Arithmetic shift after adding one half: ties go toward +inf.
  always_comb begin
    rnd = (RndW'(acc_q) + Half) >>> FRAC_BITS;
    if (RELU && rnd[RndW-1]) rnd = '0;
    out_d = rnd[15:0];
    sat_d = 1'b0;
    if (rnd > OutMax) begin
      out_d = 16'sh7fff;
      sat_d = 1'b1;
    end else if (rnd < OutMin) begin
      out_d = 16'sh8000;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      conv_out <= '0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= adv4 & sat_d;
      if (adv4) conv_out <= out_d;
    end
  end

  // A fresh kernel (weights_ready rising) restarts the count; that clear beats an increment.
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      sat_cnt <= '0;
    end else begin
      wr_q <= weights_ready;
      if (weights_ready && !wr_q) begin
        sat_cnt <= '0;
      end else if (conv_valid && sat_flag && sat_cnt != 16'hffff) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: directed and random windows on a plain and a ReLU instance, checked
// against an arithmetic reference with an in-flight window queue.
module tb_conv3x3_mac;

  localparam int F = 8;

  logic               pclk = 1'b0;
  logic               rst;
  logic               pix_valid;
  logic               weights_ready;
  logic [7:0]         pix_a [9];
  logic signed [15:0] w_a [9];
  logic signed [15:0] bias;

  logic signed [15:0] conv_out   [2];
  logic               conv_valid [2];
  logic               sat_flag   [2];
  logic [15:0]        sat_cnt    [2];

  always #5 pclk = ~pclk;

  conv3x3_mac #(.PIX_W(8), .FRAC_BITS(F), .RELU(1'b0)) dut0 (
    .pclk(pclk), .rst(rst),
    .pix_1_1(pix_a[0]), .pix_1_2(pix_a[1]), .pix_1_3(pix_a[2]),
    .pix_2_1(pix_a[3]), .pix_2_2(pix_a[4]), .pix_2_3(pix_a[5]),
    .pix_3_1(pix_a[6]), .pix_3_2(pix_a[7]), .pix_3_3(pix_a[8]),
    .pix_valid(pix_valid),
    .weights_1_1(w_a[0]), .weights_1_2(w_a[1]), .weights_1_3(w_a[2]),
    .weights_2_1(w_a[3]), .weights_2_2(w_a[4]), .weights_2_3(w_a[5]),
    .weights_3_1(w_a[6]), .weights_3_2(w_a[7]), .weights_3_3(w_a[8]),
    .bias(bias), .weights_ready(weights_ready),
    .conv_out(conv_out[0]), .conv_valid(conv_valid[0]), .sat_flag(sat_flag[0]),
    .sat_cnt(sat_cnt[0])
  );

  conv3x3_mac #(.PIX_W(8), .FRAC_BITS(F), .RELU(1'b1)) dut1 (
    .pclk(pclk), .rst(rst),
    .pix_1_1(pix_a[0]), .pix_1_2(pix_a[1]), .pix_1_3(pix_a[2]),
    .pix_2_1(pix_a[3]), .pix_2_2(pix_a[4]), .pix_2_3(pix_a[5]),
    .pix_3_1(pix_a[6]), .pix_3_2(pix_a[7]), .pix_3_3(pix_a[8]),
    .pix_valid(pix_valid),
    .weights_1_1(w_a[0]), .weights_1_2(w_a[1]), .weights_1_3(w_a[2]),
    .weights_2_1(w_a[3]), .weights_2_2(w_a[4]), .weights_2_3(w_a[5]),
    .weights_3_1(w_a[6]), .weights_3_2(w_a[7]), .weights_3_3(w_a[8]),
    .bias(bias), .weights_ready(weights_ready),
    .conv_out(conv_out[1]), .conv_valid(conv_valid[1]), .sat_flag(sat_flag[1]),
    .sat_cnt(sat_cnt[1])
  );

  typedef struct {
    int res0;
    int res1;
    bit sat0;
    bit sat1;
    int age;
  } win_t;

  win_t q [$];
  int   m_out [2];
  bit   m_sat [2];
  int   m_cnt [2];
  bit   m_valid;
  bit   m_wrp;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result of the window currently on the inputs, from plain integer arithmetic.
  function automatic void calc(input bit relu, output int res, output bit sat);
    int s;
    s = int'(bias);
    for (int i = 0; i < 9; i++) s += int'(pix_a[i]) * int'(w_a[i]);
    res = (s + (1 << (F - 1))) >>> F;
    if (relu && res < 0) res = 0;
    sat = 1'b0;
    if (res > 32767) begin
      res = 32767;
      sat = 1'b1;
    end else if (res < -32768) begin
      res = -32768;
      sat = 1'b1;
    end
  endfunction

  // One clock edge: advance the reference with the inputs seen at the edge, then compare.
  task automatic step();
    bit   ok;
    win_t t;
    win_t n;
    @(posedge pclk);
    #1;
    ok = weights_ready && !rst;
    for (int k = 0; k < 2; k++) begin
      if (rst) m_cnt[k] = 0;
      else if (weights_ready && !m_wrp) m_cnt[k] = 0;
      else if (m_valid && m_sat[k] && m_cnt[k] != 65535) m_cnt[k]++;
    end
    m_wrp   = rst ? 1'b0 : weights_ready;
    m_valid = 1'b0;
    m_sat   = '{1'b0, 1'b0};
    if (rst) m_out = '{0, 0};
    if (!ok) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        t.age++;
        q[i] = t;
      end
      if (q.size() > 0 && q[0].age == 3) begin
        t        = q.pop_front();
        m_valid  = 1'b1;
        m_out[0] = t.res0;
        m_out[1] = t.res1;
        m_sat[0] = t.sat0;
        m_sat[1] = t.sat1;
      end
      if (pix_valid) begin
        calc(1'b0, n.res0, n.sat0);
        calc(1'b1, n.res1, n.sat1);
        n.age = 0;
        q.push_back(n);
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("conv_valid[%0d]", k), 16'(conv_valid[k]), 16'(m_valid));
      chk($sformatf("sat_flag[%0d]", k), 16'(sat_flag[k]), 16'(m_sat[k]));
      chk($sformatf("conv_out[%0d]", k), conv_out[k], 16'(m_out[k]));
      chk($sformatf("sat_cnt[%0d]", k), sat_cnt[k], 16'(m_cnt[k]));
    end
    if (conv_valid[0] === 1'b1) vcount++;
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic load(input logic [15:0] wv, input logic [15:0] bv);
    weights_ready = 1'b0;
    pix_valid     = 1'b0;
    for (int i = 0; i < 9; i++) w_a[i] = wv;
    bias = bv;
    step();
    weights_ready = 1'b1;
  endtask

  task automatic set_pix(input logic [7:0] pv);
    for (int i = 0; i < 9; i++) pix_a[i] = pv;
  endtask

  initial begin
    rst           = 1'b1;
    pix_valid     = 1'b0;
    weights_ready = 1'b0;
    bias          = '0;
    set_pix(8'd0);
    for (int i = 0; i < 9; i++) w_a[i] = '0;
    m_out   = '{0, 0};
    m_sat   = '{1'b0, 1'b0};
    m_cnt   = '{0, 0};
    m_valid = 1'b0;
    m_wrp   = 1'b0;

    // Reset state
    steps(2);
    rst = 1'b0;

    // Uniform kernel: single window of 10s gives 90
    load(16'h0100, 16'h0000);
    set_pix(8'd10);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    steps(5);
    chk("uniform_out", conv_out[0], 16'd90);

    // Rounding: 3 * 0.5 = 1.5 rounds up to 2
    load(16'h0000, 16'h0000);
    w_a[4] = 16'h0080;
    set_pix(8'd0);
    pix_a[4]  = 8'd3;
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    steps(5);
    chk("round_half_up", conv_out[0], 16'd2);

    // Bias -0.5 with zero pixels rounds to 0
    load(16'h0100, 16'hff80);
    set_pix(8'd0);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    steps(5);
    chk("bias_neg_half", conv_out[0], 16'd0);

    // Positive saturation, three back-to-back windows
    load(16'h7fff, 16'h0000);
    set_pix(8'd255);
    pix_valid = 1'b1;
    steps(3);
    pix_valid = 1'b0;
    steps(5);
    chk("sat_pos_out", conv_out[0], 16'h7fff);
    chk("sat_pos_cnt", sat_cnt[0], 16'd3);

    // Negative saturation; ReLU instance clamps instead of saturating
    load(16'h8000, 16'h0000);
    pix_valid = 1'b1;
    steps(3);
    pix_valid = 1'b0;
    steps(5);
    chk("sat_neg_out", conv_out[0], 16'h8000);
    chk("sat_neg_relu_out", conv_out[1], 16'd0);
    chk("sat_neg_relu_cnt", sat_cnt[1], 16'd0);

    // ReLU: -90 plain, 0 clamped
    load(16'hff00, 16'h0000);
    set_pix(8'd10);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    steps(5);
    chk("relu_off_out", conv_out[0], 16'hffa6);
    chk("relu_on_out", conv_out[1], 16'd0);

    // Flush on reload: windows 1-3, one low cycle, windows 4-6; only 4-6 emerge
    load(16'h0100, 16'h0000);
    vcount    = 0;
    pix_valid = 1'b1;
    steps(3);
    weights_ready = 1'b0;
    step();
    weights_ready = 1'b1;
    steps(3);
    pix_valid = 1'b0;
    steps(5);
    chk("flush_count", 16'(vcount), 16'd3);
    chk("flush_out", conv_out[0], 16'd90);

    // Random windows, random kernels, occasional reloads
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0 || n == 0) begin
        weights_ready = 1'b0;
        pix_valid     = 1'b0;
        for (int i = 0; i < 9; i++) begin
          w_a[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 511) - 256);
        end
        bias = 16'($urandom);
        steps($urandom_range(1, 2));
        weights_ready = 1'b1;
      end
      for (int i = 0; i < 9; i++) pix_a[i] = 8'($urandom);
      pix_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    pix_valid = 1'b0;
    steps(5);

    // Reset mid-stream
    load(16'h0100, 16'h0000);
    set_pix(8'd10);
    pix_valid = 1'b1;
    steps(3);
    pix_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    vcount = 0;
    steps(6);
    chk("rst_no_valid", 16'(vcount), 16'd0);
    chk("rst_out", conv_out[0], 16'd0);
    chk("rst_cnt", sat_cnt[0], 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
